// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the two-master GPIO access arbiter.
// The legality helper is the single source of truth for which accesses reach the port.
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [1:0] GPIO_OUT_OFS = 2'h0;
  localparam logic [1:0] GPIO_IN_OFS  = 2'h1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Writes only to the LED word, reads only from the switch byte; anything else is rejected.
  function automatic logic access_legal(input logic [31:0] addr, input logic we,
                                        input logic [31:0] base);
    logic hit;
    hit = (addr[31:2] == base[31:2]);
    return hit && ((we && (addr[1:0] == GPIO_OUT_OFS)) || (!we && (addr[1:0] == GPIO_IN_OFS)));
  endfunction

endpackage

// File: rtl/gpio_access_arbiter_if.sv
// Per-master request/acknowledge bus into the GPIO access arbiter.
interface gpio_access_arbiter_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, err, rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input picker: round-robin on simultaneous requests, or fixed M0 priority.
// The pointer always moves to the master that did not win the last grant.
module rr_arb2
  import gpio_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       fixed_prio_i,
  input  logic       advance_i,
  output logic       gnt_id_o
);

  logic ptr_q;

  always_comb begin
    gnt_id_o = M0;
    if (fixed_prio_i) begin
      gnt_id_o = req_i[0] ? M0 : M1;
    end else if (&req_i) begin
      gnt_id_o = ptr_q;
    end else begin
      gnt_id_o = req_i[1] ? M1 : M0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= M0;
    end else if (advance_i) begin
      ptr_q <= ~gnt_id_o;
    end
  end

endmodule

// File: rtl/gpio_access_arbiter.sv
// Shares one GPIO port between two masters: grant, validate, one-cycle GPIO strobe, ack.
// Every output is a flop, so an asynchronous reset drops the strobe without a clock.
module gpio_access_arbiter
  import gpio_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0024,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  gpio_access_arbiter_if.slave        m0,
  gpio_access_arbiter_if.slave        m1,
  output logic                        gpio_select,
  output logic [31:0]                 gpio_address,
  output logic [31:0]                 gpio_datain,
  input  logic [31:0]                 gpio_dataout,
  output logic                        busy,
  output logic                        owner
);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic             id_q, id_d;
  logic             owner_q, owner_d;
  logic             busy_q;
  logic             sel_q, sel_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;

  logic [1:0]  req_vec;
  logic        gnt_id;
  logic        advance;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // Only the switch byte of the port is meaningful.
  logic unused_dataout;
  assign unused_dataout = ^gpio_dataout[31:8];

  assign req_vec   = {m1.req, m0.req};
  assign sel_we    = (gnt_id == M1) ? m1.we    : m0.we;
  assign sel_addr  = (gnt_id == M1) ? m1.addr  : m0.addr;
  assign sel_wdata = (gnt_id == M1) ? m1.wdata : m0.wdata;

  rr_arb2 u_rr_arb2 (
    .clk_i        (clk),
    .rst_ni       (rst),
    .req_i        (req_vec),
    .fixed_prio_i (FIXED_PRIO),
    .advance_i    (advance),
    .gnt_id_o     (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    id_d    = id_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req_vec) begin
          advance = 1'b1;
          id_d    = gnt_id;
          owner_d = gnt_id;
          we_d    = sel_we;
          if (access_legal(sel_addr, sel_we, BASE_ADDR)) begin
            sel_d   = 1'b1;
            addr_d  = sel_addr;
            din_d   = sel_wdata;
            state_d = ACCESS;
          end else begin
            // Rejected accesses never touch the port; they complete straight away.
            ack_d[gnt_id]   = 1'b1;
            err_d[gnt_id]   = 1'b1;
            rdata_d[gnt_id] = '0;
            state_d         = DONE;
          end
        end
      end
      ACCESS: begin
        sel_d         = 1'b0;
        addr_d        = '0;
        din_d         = '0;
        ack_d[id_q]   = 1'b1;
        err_d[id_q]   = 1'b0;
        rdata_d[id_q] = we_q ? 32'h0 : {24'h0, gpio_dataout[7:0]};
        state_d       = DONE;
      end
      DONE: begin
        ack_d   = '0;
        err_d   = '0;
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      id_q    <= M0;
      owner_q <= M0;
      busy_q  <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      id_q    <= id_d;
      owner_q <= owner_d;
      busy_q  <= (state_d != IDLE);
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign gpio_select  = sel_q;
  assign gpio_address = addr_q;
  assign gpio_datain  = din_q;
  assign busy         = busy_q;
  assign owner        = owner_q;

  assign m0.ack   = ack_q[M0];
  assign m0.err   = err_q[M0];
  assign m0.rdata = rdata_q[M0];
  assign m1.ack   = ack_q[M1];
  assign m1.err   = err_q[M1];
  assign m1.rdata = rdata_q[M1];

endmodule

// File: doc/gpio_access_arbiter.md
Name: gpio_access_arbiter

Overview:
Shares the single GPIO port between two bus masters: M0, the CPU data port, and M1, a debug/DMA master. It decodes and validates each access, then drives the GPIO select, address and data lines for exactly one clock. It captures the read data and returns a one-cycle acknowledge to the owning master. Illegal accesses are blocked so a read can never corrupt the LED register.

Parameters:
BASE_ADDR, 32'h1001_0024, word-aligned GPIO base; a request hits when addr[31:2] == BASE_ADDR[31:2].
FIXED_PRIO, 0, 0 selects round-robin; 1 makes M0 always win simultaneous requests.

Ports:
clk  input  1  system clock; all state changes on posedge.
rst  input  1  asynchronous, active-low reset.
m0_req / m1_req  input  1  request; held high until the matching ack.
m0_we / m1_we  input  1  1 = write, 0 = read.
m0_addr / m1_addr  input  32  byte address.
m0_wdata / m1_wdata  input  32  write data; only bits [7:0] are used.
m0_ack / m1_ack  output  1  one-cycle completion pulse.
m0_err / m1_err  output  1  valid with ack; 1 = access rejected.
m0_rdata / m1_rdata  output  32  valid with ack; {24'b0, switch byte}.
gpio_select  output  1  GPIO port select.
gpio_address  output  32  GPIO address.
gpio_datain  output  32  data to GPIO.
gpio_dataout  input  32  read data from GPIO.
busy  output  1  high whenever state != IDLE.
owner  output  1  ID of the last granted master.

Behaviour:
- All outputs are registered.
- Reset (rst = 0, asynchronous): state = IDLE, RR pointer = 0, all outputs = 0.
- Reset mid-transaction aborts it immediately: no ack is issued, gpio_select drops without waiting for a clock.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, request present: pick a winner.
  - FIXED_PRIO = 1: M0 wins.
  - FIXED_PRIO = 0: if both request, the RR pointer's master wins.
  - After any grant, the pointer moves to the other master.
  - Latch the winner's addr, we, wdata and ID. owner = winner.
- Legality check on the latched request (offset = addr[1:0]):
  - Legal: address hit AND ((we = 1 AND offset = 2'h0) OR (we = 0 AND offset = 2'h1)).
  - Legal: gpio_select = 1, gpio_address = latched addr, gpio_datain = latched wdata, next state = ACCESS.
  - Illegal (miss, offset 2/3, read of offset 0, write to offset 1): gpio_select stays 0, err = 1, next state = DONE.
- ACCESS lasts one cycle. The GPIO acts on the falling edge inside this cycle.
- On the posedge leaving ACCESS:
  - Capture rdata = {24'b0, gpio_dataout[7:0]} on reads; rdata = 0 on writes.
  - gpio_select = 0; gpio_address and gpio_datain return to 0.
  - Winner's ack = 1, err = 0. Next state = DONE.
- DONE: ack, err and rdata are visible for exactly this one cycle. The master drops req at the next posedge. Next state = IDLE; ack clears.
- The loser's ack, err and rdata stay 0 throughout.
- Latency: req sampled at posedge E0 → gpio_select high E0–E1 → ack high E1–E2. Throughput is one transaction per 3 cycles.
- A req still high when IDLE samples it again starts a new transaction (master protocol violation; not filtered).
- A request arriving during ACCESS or DONE waits; no request is ever dropped.

Decomposition:
- Package gpio_arb_pkg:
  - State enum {IDLE, ACCESS, DONE}.
  - GPIO_OUT_OFS = 2'h0, GPIO_IN_OFS = 2'h1.
  - Master ID constants M0 = 1'b0, M1 = 1'b1.
- Sub-module rr_arb2: 2-input round-robin picker with pointer register, a FIXED_PRIO input and an advance strobe. Instantiated once.

Test Plan:
- Write: M0 writes 32'h0000_00A5 to BASE_ADDR + 0 → gpio_select high 1 cycle with gpio_address = BASE_ADDR, gpio_datain[7:0] = 8'hA5; m0_ack at cycle 2; m0_err = 0; LEDs = 8'hA5.
- Read: switches = 8'h3C; M1 reads BASE_ADDR + 1 → m1_rdata = 32'h0000_003C with m1_ack; LEDs unchanged.
- Illegal accesses: M0 reads BASE_ADDR + 0; separately, M0 writes BASE_ADDR + 1 → gpio_select never asserts; m0_ack = 1 with m0_err = 1 one cycle after sampling; LEDs unchanged.
- Contention, FIXED_PRIO = 0: both masters hold req continuously → grants alternate M0, M1, M0, M1; each ack 3 cycles apart.
- Contention, FIXED_PRIO = 1: both masters hold req → M0 wins every time.
- Reset during ACCESS: drive rst low while gpio_select = 1 → gpio_select, acks and busy go to 0 immediately; after release, the first grant goes to M0.
- Address miss: M1 writes to BASE_ADDR + 4 → m1_err = 1; GPIO untouched.
